// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Fetch-unit bundle: instruction-memory request/response,
//               redirect input and decode handoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  // master: the fetch unit itself
  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instruction, pc
  );

  // slave: memory/decode/branch side
  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instruction, pc
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : Single-outstanding instruction fetch unit with redirect and
//               decode handoff; BOOT -> REQ -> WAIT -> HOLD loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  instruction_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        discard;
  logic        req;
  logic        valid;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Redirect targets are word aligned; the low bits carry no information.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      req      <= 1'b0;
      valid    <= 1'b0;
      instr_q  <= 32'h0;
      pc_q     <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (bus.imem_gnt) begin
            state   <= WAIT;
            req     <= 1'b0;
            discard <= bus.redirect;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            discard <= 1'b0;
            if (discard || bus.redirect) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              state   <= HOLD;
              valid   <= 1'b1;
              instr_q <= bus.imem_rdata;
              pc_q    <= fetch_pc;
            end
          end else if (bus.redirect) begin
            // Response still in flight for the old path; drop it on arrival.
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.redirect || bus.instr_ready) begin
            state <= REQ;
            req   <= 1'b1;
            valid <= 1'b0;
            if (!bus.redirect) begin
              fetch_pc <= fetch_pc + 32'd4;
            end
          end
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
      // Last assignment wins: redirect overrides any sequential increment.
      if (bus.redirect) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed bench for instruction_fetch with a transaction-level
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: next address to fetch, one outstanding request, one held word.
  logic        m_boot, m_out, m_stale, m_held;
  logic [31:0] m_addr, m_oaddr, m_hpc, m_hdata;
  logic        exp_req, old_held;
  logic [31:0] hand_pc[$];
  logic [31:0] hand_ins[$];
  int          hand_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req",   {31'h0, bus.imem_req},    32'h0);
      chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
      chk("rst_addr",  bus.imem_addr,   RESET_PC);
      chk("rst_instr", bus.instruction, 32'h0);
      chk("rst_pc",    bus.pc,          32'h0);
      m_boot  = 1'b1;
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_held  = 1'b0;
      m_addr  = RESET_PC;
      m_oaddr = RESET_PC;
      m_hpc   = 32'h0;
      m_hdata = 32'h0;
    end else begin
      exp_req = !m_boot && !m_out && !m_held;
      chk("req", {31'h0, bus.imem_req}, {31'h0, exp_req});
      if (exp_req) chk("addr", bus.imem_addr, m_addr);
      chk("valid", {31'h0, bus.instr_valid}, {31'h0, m_held});
      if (m_held) begin
        chk("pc", bus.pc, m_hpc);
        chk("instr", bus.instruction, m_hdata);
      end
      old_held = m_held;
      if (m_out && bus.imem_rvalid) begin
        if (!m_stale && !bus.redirect) begin
          m_held  = 1'b1;
          m_hpc   = m_oaddr;
          m_hdata = bus.imem_rdata;
        end
        m_out = 1'b0;
      end else if (exp_req && bus.imem_gnt) begin
        m_out   = 1'b1;
        m_oaddr = m_addr;
        m_stale = bus.redirect;
      end else if (m_out && bus.redirect) begin
        m_stale = 1'b1;
      end
      if (old_held) begin
        if (bus.redirect) begin
          m_held = 1'b0;
        end else if (bus.instr_ready) begin
          hand_pc.push_back(m_hpc);
          hand_ins.push_back(m_hdata);
          hand_cyc.push_back(cyc);
          m_held = 1'b0;
          m_addr = m_hpc + 32'd4;
        end
      end
      m_boot = 1'b0;
      if (bus.redirect) m_addr = {bus.redirect_pc[31:2], 2'b00};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.imem_rdata = m_oaddr ^ KEY;
  endtask

  task automatic clear_log();
    hand_pc.delete();
    hand_ins.delete();
    hand_cyc.delete();
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;

    // Hold with decode stalled, then stream 0,4,8 with a 3-cycle period.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !bus.instr_valid; i++) tick();
    chk("hold_reach", {31'h0, bus.instr_valid}, 32'h1);
    repeat (5) begin
      tick();
      chk("hold_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("hold_req",   {31'h0, bus.imem_req},    32'h0);
      chk("hold_pc",    bus.pc,          32'h0);
      chk("hold_instr", bus.instruction, 32'hA5A5_0000);
    end
    clear_log();
    bus.instr_ready = 1'b1;
    repeat (10) tick();
    chk("stream_count", {31'h0, hand_pc.size() >= 3}, 32'h1);
    if (hand_pc.size() >= 3) begin
      chk("stream_pc0", hand_pc[0], 32'h0);
      chk("stream_pc1", hand_pc[1], 32'h4);
      chk("stream_pc2", hand_pc[2], 32'h8);
      chk("stream_ins2", hand_ins[2], 32'hA5A5_0008);
      chk("stream_gap", hand_cyc[2] - hand_cyc[1], 32'd3);
    end

    // Redirect in the same cycle as the grant for 0x8.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30 && !(bus.imem_req && bus.imem_addr == 32'h8); i++) tick();
    chk("b_reach8", {31'h0, bus.imem_req && bus.imem_addr == 32'h8}, 32'h1);
    clear_log();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_1003;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 10 && !bus.imem_req; i++) tick();
    chk("b_addr", bus.imem_addr, 32'h0000_1000);
    for (int i = 0; i < 10 && hand_pc.size() == 0; i++) tick();
    chk("b_count", {31'h0, hand_pc.size() >= 1}, 32'h1);
    if (hand_pc.size() >= 1) begin
      chk("b_pc",  hand_pc[0],  32'h0000_1000);
      chk("b_ins", hand_ins[0], 32'hA5A5_1000);
    end

    // Redirect while presenting pc=0x10 with decode ready: no 0x14.
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0010;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 20 && !(bus.instr_valid && bus.pc == 32'h10); i++) tick();
    chk("c_hold10", {31'h0, bus.instr_valid && bus.pc == 32'h10}, 32'h1);
    clear_log();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0;
    chk("c_drop", {31'h0, bus.instr_valid}, 32'h0);
    for (int i = 0; i < 10 && !bus.imem_req; i++) tick();
    chk("c_addr", bus.imem_addr, 32'h0000_0200);
    for (int i = 0; i < 10 && hand_pc.size() == 0; i++) tick();
    chk("c_count", {31'h0, hand_pc.size() >= 1}, 32'h1);
    if (hand_pc.size() >= 1) chk("c_pc", hand_pc[0], 32'h0000_0200);

    // Wrap of the sequential fetch address.
    clear_log();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 20 && hand_pc.size() < 2; i++) tick();
    chk("d_count", {31'h0, hand_pc.size() >= 2}, 32'h1);
    if (hand_pc.size() >= 2) begin
      chk("d_pc0", hand_pc[0], 32'hFFFF_FFFC);
      chk("d_pc1", hand_pc[1], 32'h0);
      chk("d_ins1", hand_ins[1], KEY);
    end

    // Mixed handshakes and redirects, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      bus.imem_gnt    = 1'($urandom_range(0, 1));
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      bus.instr_ready = 1'($urandom_range(0, 1));
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
      tick();
    end
    bus.redirect = 1'b0;

    // Reset during WAIT, then a late response that must be ignored.
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    tick();
    chk("f_in_wait", {31'h0, bus.imem_req}, 32'h0);
    rst_n = 1'b0;
    repeat (2) tick();
    clear_log();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk("f_first_req",  {31'h0, bus.imem_req}, 32'h1);
    chk("f_first_addr", bus.imem_addr, RESET_PC);
    tick();
    bus.imem_rvalid = 1'b0;
    repeat (3) begin
      tick();
      chk("f_no_valid", {31'h0, bus.instr_valid}, 32'h0);
    end
    bus.imem_rvalid = 1'b1;
    for (int i = 0; i < 10 && hand_pc.size() == 0; i++) tick();
    chk("f_count", {31'h0, hand_pc.size() >= 1}, 32'h1);
    if (hand_pc.size() >= 1) begin
      chk("f_pc",  hand_pc[0],  RESET_PC);
      chk("f_ins", hand_ins[0], RESET_PC ^ KEY);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
